// File: rtl/eq_stream_checker.sv
// eq_stream_checker: registers per-sample equality of (x, y), tracks runs of
// consecutive matches, locks after RUN_LEN matches, tolerates one isolated
// mismatch while locked, and keeps saturating run/mismatch statistics.
module eq_stream_checker #(
  parameter int W       = 2,
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  input  logic             clear,
  output logic             eq,
  output logic             eq_valid,
  output logic [CNT_W-1:0] run_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             locked,
  output logic             lost
);

  // The fourth 2-bit code is deliberately left out; it falls into the
  // default arm and recovers to SEARCH.
  typedef enum logic [1:0] {
    S_SEARCH = 2'b00,
    S_LOCKED = 2'b01,
    S_HOLD   = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] RUN_LEN_C = CNT_W'(RUN_LEN);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] run_d, mis_d;
  logic             eq_d, eq_valid_d, lost_d;
  logic             match;

  assign match = (x == y);

  // Next-state, next-statistics and next-output computation for one edge.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned; that is what keeps this block free of inferred latches.
    state_d    = state_q;
    run_d      = run_cnt;
    mis_d      = mismatch_cnt;
    eq_d       = eq;
    eq_valid_d = 1'b0;
    lost_d     = 1'b0;

    if (in_valid) begin
      eq_valid_d = 1'b1;
      eq_d       = match;
      if (match) begin
        run_d = (run_cnt == CNT_MAX) ? run_cnt : run_cnt + CNT_ONE;
      end else begin
        run_d = '0;
        mis_d = (mismatch_cnt == CNT_MAX) ? mismatch_cnt : mismatch_cnt + CNT_ONE;
      end
    end

    case (state_q)
      S_SEARCH: begin
        if (in_valid && match && (run_d >= RUN_LEN_C)) state_d = S_LOCKED;
      end
      S_LOCKED: begin
        if (in_valid && !match) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (in_valid) begin
          if (match) begin
            state_d = S_LOCKED;
          end else begin
            state_d = S_SEARCH;
            lost_d  = 1'b1;
          end
        end
      end
      default: state_d = S_SEARCH;
    endcase
  end

  // State and output registers; reset and soft clear have identical effect.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n || clear) begin
      state_q      <= S_SEARCH;
      eq           <= 1'b0;
      eq_valid     <= 1'b0;
      run_cnt      <= '0;
      mismatch_cnt <= '0;
      lost         <= 1'b0;
    end else begin
      state_q      <= state_d;
      eq           <= eq_d;
      eq_valid     <= eq_valid_d;
      run_cnt      <= run_d;
      mismatch_cnt <= mis_d;
      lost         <= lost_d;
    end
  end

  // locked is decoded straight from the state register, so it stays
  // registered with no path from the inputs.
  assign locked = (state_q == S_LOCKED) || (state_q == S_HOLD);

endmodule

// File: tb/tb_eq_stream_checker.sv
// Self-checking bench for eq_stream_checker: two instances (default and a
// narrow-counter variant) share one directed stimulus stream; a behavioural
// model of each is compared every cycle, plus hand-computed expectations.
module tb_eq_stream_checker;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, clear;
  logic [1:0] x, y;

  logic       eq_a, ev_a, lk_a, lost_a;
  logic [7:0] run_a, mis_a;
  logic       eq_b, ev_b, lk_b, lost_b;
  logic [2:0] run_b, mis_b;

  int checks   = 0;
  int failures = 0;
  bit armed    = 1'b0;

  always #5 clk = ~clk;

  eq_stream_checker #(.W(2), .RUN_LEN(4), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .y(y), .clear(clear),
    .eq(eq_a), .eq_valid(ev_a), .run_cnt(run_a), .mismatch_cnt(mis_a),
    .locked(lk_a), .lost(lost_a)
  );

  eq_stream_checker #(.W(2), .RUN_LEN(7), .CNT_W(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .y(y), .clear(clear),
    .eq(eq_b), .eq_valid(ev_b), .run_cnt(run_b), .mismatch_cnt(mis_b),
    .locked(lk_b), .lost(lost_b)
  );

  // Behavioural model: counters as plain integers, lock tracked as
  // "locked" plus "one strike already used".
  typedef struct packed {
    int run;
    int mis;
    bit lk;
    bit strike;
    bit eq;
    bit ev;
    bit lost;
  } model_t;

  model_t ma = '0;
  model_t mb = '0;

  function automatic model_t model_step(model_t m, int run_len, int max_cnt,
                                        bit v, bit match, bit clr, bit rst);
    model_t n;
    if (rst || clr) return '0;
    n      = m;
    n.ev   = 1'b0;
    n.lost = 1'b0;
    if (v) begin
      n.ev = 1'b1;
      n.eq = match;
      if (match) begin
        n.run = (m.run < max_cnt) ? m.run + 1 : max_cnt;
        if (n.lk) n.strike = 1'b0;
        else if (n.run >= run_len) n.lk = 1'b1;
      end else begin
        n.run = 0;
        n.mis = (m.mis < max_cnt) ? m.mis + 1 : max_cnt;
        if (n.lk) begin
          if (n.strike) begin
            n.lk     = 1'b0;
            n.strike = 1'b0;
            n.lost   = 1'b1;
          end else begin
            n.strike = 1'b1;
          end
        end
      end
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance both models on every rising edge using the stable inputs.
  always @(posedge clk) begin
    ma = model_step(ma, 4, 255, in_valid, x == y, clear, !rst_n);
    mb = model_step(mb, 7, 7,   in_valid, x == y, clear, !rst_n);
    if (!rst_n) armed = 1'b1;
  end

  // Compare both DUTs against their models on every falling edge.
  always @(negedge clk) begin
    if (armed) begin
      check("a_eq", 32'(eq_a), 32'(ma.eq));
      check("a_eq_valid", 32'(ev_a), 32'(ma.ev));
      check("a_run_cnt", 32'(run_a), ma.run);
      check("a_mismatch_cnt", 32'(mis_a), ma.mis);
      check("a_locked", 32'(lk_a), 32'(ma.lk));
      check("a_lost", 32'(lost_a), 32'(ma.lost));
      check("b_eq", 32'(eq_b), 32'(mb.eq));
      check("b_eq_valid", 32'(ev_b), 32'(mb.ev));
      check("b_run_cnt", 32'(run_b), mb.run);
      check("b_mismatch_cnt", 32'(mis_b), mb.mis);
      check("b_locked", 32'(lk_b), 32'(mb.lk));
      check("b_lost", 32'(lost_b), 32'(mb.lost));
    end
  end

  // One clock of stimulus: drive at the falling edge, return at the next one.
  task automatic step(input bit v, input logic [1:0] a, input logic [1:0] b,
                      input bit clr, input bit rst);
    in_valid = v;
    x        = a;
    y        = b;
    clear    = clr;
    rst_n    = ~rst;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic sample(input logic [1:0] a, input logic [1:0] b);
    step(1'b1, a, b, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic expect_a(input string tag, input bit e, input bit ev, input int run,
                          input int mis, input bit lk, input bit lst);
    check({tag, "_eq"}, 32'(eq_a), 32'(e));
    check({tag, "_eq_valid"}, 32'(ev_a), 32'(ev));
    check({tag, "_run_cnt"}, 32'(run_a), run);
    check({tag, "_mismatch_cnt"}, 32'(mis_a), mis);
    check({tag, "_locked"}, 32'(lk_a), 32'(lk));
    check({tag, "_lost"}, 32'(lost_a), 32'(lst));
  endtask

  task automatic expect_b(input string tag, input bit e, input bit ev, input int run,
                          input int mis, input bit lk, input bit lst);
    check({tag, "_eq"}, 32'(eq_b), 32'(e));
    check({tag, "_eq_valid"}, 32'(ev_b), 32'(ev));
    check({tag, "_run_cnt"}, 32'(run_b), run);
    check({tag, "_mismatch_cnt"}, 32'(mis_b), mis);
    check({tag, "_locked"}, 32'(lk_b), 32'(lk));
    check({tag, "_lost"}, 32'(lost_b), 32'(lst));
  endtask

  logic [1:0] t3x [8] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [1:0] t3y [8] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};
  int         t3run [8] = '{1, 2, 3, 0, 1, 2, 3, 4};

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    x        = 2'd1;
    y        = 2'd1;
    clear    = 1'b0;
    @(negedge clk);

    // 1: reset held with a matching sample presented; then first sample.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'd1, 2'd1, 1'b0, 1'b1);
      expect_a("t1_rst", 0, 0, 0, 0, 0, 0);
    end
    sample(2'd1, 2'd1);
    expect_a("t1_first", 1, 1, 1, 0, 0, 0);
    idle();
    expect_a("t1_idle", 1, 0, 1, 0, 0, 0);
    step(1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
    expect_a("t1_clear", 0, 0, 0, 0, 0, 0);

    // 2: four back-to-back matches lock on the fourth.
    sample(2'd1, 2'd1); expect_a("t2_s1", 1, 1, 1, 0, 0, 0);
    sample(2'd2, 2'd2); expect_a("t2_s2", 1, 1, 2, 0, 0, 0);
    sample(2'd3, 2'd3); expect_a("t2_s3", 1, 1, 3, 0, 0, 0);
    sample(2'd0, 2'd0); expect_a("t2_s4", 1, 1, 4, 0, 1, 0);
    step(1'b0, 2'd0, 2'd0, 1'b1, 1'b0);

    // 3: a mismatch in SEARCH restarts the run; idle gaps change nothing.
    for (int i = 0; i < 8; i++) begin
      sample(t3x[i], t3y[i]);
      expect_a("t3_smp", (i != 3), 1, t3run[i], (i >= 3) ? 1 : 0, (i == 7), 0);
      for (int g = 0; g < 2; g++) begin
        idle();
        expect_a("t3_gap", (i != 3), 0, t3run[i], (i >= 3) ? 1 : 0, (i == 7), 0);
      end
    end

    // 4: one tolerated mismatch, recovery, then loss of lock.
    sample(2'd3, 2'd2); expect_a("t4_hold", 0, 1, 0, 2, 1, 0);
    sample(2'd2, 2'd2); expect_a("t4_relock", 1, 1, 1, 2, 1, 0);
    sample(2'd0, 2'd1); expect_a("t4_hold2", 0, 1, 0, 3, 1, 0);
    sample(2'd0, 2'd2); expect_a("t4_lost", 0, 1, 0, 4, 0, 1);
    idle();             expect_a("t4_after", 0, 0, 0, 4, 0, 0);

    // 5: clear while locked drops the concurrent sample and never pulses lost.
    for (int i = 0; i < 4; i++) sample(2'd1, 2'd1);
    expect_a("t5_lock", 1, 1, 4, 4, 1, 0);
    step(1'b1, 2'd3, 2'd3, 1'b1, 1'b0);
    expect_a("t5_clear", 0, 0, 0, 0, 0, 0);
    sample(2'd3, 2'd3);
    expect_a("t5_next", 1, 1, 1, 0, 0, 0);

    // 6: narrow counters saturate; lock after 7; reset mid-stream.
    step(1'b1, 2'd1, 2'd1, 1'b0, 1'b1);
    expect_b("t6_rst", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      sample(2'd2, 2'd2);
      expect_b("t6_match", 1, 1, (i < 7) ? i + 1 : 7, 0, (i >= 6), 0);
    end
    for (int i = 0; i < 9; i++) begin
      sample(2'd1, 2'd2);
      expect_b("t6_mism", 0, 1, 0, (i < 7) ? i + 1 : 7, (i == 0), (i == 1));
    end
    step(1'b1, 2'd1, 2'd1, 1'b0, 1'b1);
    expect_b("t6_midrst", 0, 0, 0, 0, 0, 0);
    expect_a("t6_midrst_a", 0, 0, 0, 0, 0, 0);
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
